// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell feeds a registered borrow; results appear with a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             sa;
    logic             sb;

    logic x;
    logic y;
    logic d;
    logic borrow_nxt;
    logic last;

    // Full-subtractor cell on the current LSBs
    always_comb begin
        x          = a_sr[0];
        y          = b_sr[0];
        d          = x ^ y ^ borrow;
        borrow_nxt = (~x & y) | (~(x ^ y) & borrow);
        last       = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The A register doubles as the result register: each difference bit enters
    // at the MSB as the consumed minuend bit leaves at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        sa     <= a[WIDTH-1];
                        sb     <= b[WIDTH-1];
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= {d, a_sr[WIDTH-1:1]};
                    b_sr   <= b_sr >> 1;
                    borrow <= borrow_nxt;
                    if (!last) cnt <= cnt + 1'b1;
                    // Outputs are loaded only on the final bit, so partial sums never show
                    if (last) begin
                        diff <= {d, a_sr[WIDTH-1:1]};
                        bout <= borrow_nxt;
                        ovf  <= (sa ^ sb) & (sa ^ d);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 directed cases plus WIDTH=4 exhaustive sweep.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0] a8, b8, diff8;
    logic       start4, bin4, busy4, done4, bout4, ovf4;
    logic [3:0] a4, b4, diff4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [9:0] q8[$];
    logic [5:0] q4[$];
    int         done_t8[$];

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: wide unsigned subtraction for diff/bout, true signed range test for ovf
    function automatic logic [9:0] exp8(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] f;
        int         s;
        f = {1'b0, x} - {1'b0, y} - {8'd0, c};
        s = int'($signed(x)) - int'($signed(y)) - int'(c);
        return {(s < -128 || s > 127), f[8], f[7:0]};
    endfunction

    function automatic logic [5:0] exp4(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [4:0] f;
        int         s;
        f = {1'b0, x} - {1'b0, y} - {4'd0, c};
        s = int'($signed(x)) - int'($signed(y)) - int'(c);
        return {(s < -8 || s > 7), f[4], f[3:0]};
    endfunction

    always @(negedge clk) begin
        if (done8) begin
            done_t8.push_back(cyc);
            if (q8.size() == 0) chk("unexpected_done8", 1, 0);
            else begin
                logic [9:0] e;
                e = q8.pop_front();
                chk("diff8", diff8, e[7:0]);
                chk("bout8", bout8, e[8]);
                chk("ovf8", ovf8, e[9]);
            end
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) chk("unexpected_done4", 1, 0);
            else begin
                logic [5:0] e;
                e = q4.pop_front();
                chk("diff4", diff4, e[3:0]);
                chk("bout4", bout4, e[4]);
                chk("ovf4", ovf4, e[5]);
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        int n = 0;
        while ((busy8 || done8) && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("idle_timeout8", 0, 1);
        a8 = ta; b8 = tb; bin8 = tc; start8 = 1'b1;
        q8.push_back(exp8(ta, tb, tc));
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        int n = 0;
        while ((busy4 || done4) && n < 30) begin @(posedge clk); #1; n++; end
        if (n >= 30) chk("idle_timeout4", 0, 1);
        a4 = ta; b4 = tb; bin4 = tc; start4 = 1'b1;
        q4.push_back(exp4(ta, tb, tc));
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < limit) begin @(posedge clk); #1; n++; end
        if (n >= limit) chk("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h11; bin8 = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start8 = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_diff", diff8, 0);
        chk("rst_bout", bout8, 0);
        chk("rst_ovf", ovf8, 0);
        @(posedge clk); #1;

        // Timing: busy for WIDTH cycles, done in the next, diff stable throughout
        run8(8'h05, 8'h03, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("lat_busy", busy8, 1);
            chk("lat_done_early", done8, 0);
            chk("diff_hold", diff8, 0);
        end
        @(negedge clk);
        chk("lat_done", done8, 1);
        chk("lat_busy_off", busy8, 0);
        @(negedge clk);
        chk("done_pulse", done8, 0);
        @(posedge clk); #1;

        run8(8'h03, 8'h05, 1'b0);
        run8(8'h00, 8'h00, 1'b1);
        run8(8'h80, 8'h01, 1'b0);
        run8(8'h7F, 8'hFF, 1'b0);
        run8(8'h3C, 8'h3C, 1'b0);
        run8(8'hFF, 8'hFF, 1'b1);
        run8(8'h80, 8'h00, 1'b1);
        drain(100);

        // Start during SHIFT is ignored and operand changes after acceptance are harmless
        run8(8'h10, 8'h01, 1'b0);
        @(posedge clk); #1;
        a8 = 8'hAA; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h55; b8 = 8'h33; bin8 = 1'b1;
        drain(50);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back with start held high
        done_t8.delete();
        begin
            int pushes = 0;
            int n = 0;
            a8 = 8'h21; b8 = 8'h42; bin8 = 1'b1; start8 = 1'b1;
            while (pushes < 3 && n < 60) begin
                if (!busy8 && !done8) begin
                    q8.push_back(exp8(8'h21, 8'h42, 1'b1));
                    pushes++;
                end
                @(posedge clk); #1;
                n++;
            end
            start8 = 1'b0;
        end
        drain(50);
        chk("b2b_count", done_t8.size(), 3);
        if (done_t8.size() == 3) begin
            chk("b2b_gap0", done_t8[1] - done_t8[0], 10);
            chk("b2b_gap1", done_t8[2] - done_t8[1], 10);
        end

        // Reset on the 4th SHIFT cycle discards the operation
        a8 = 8'h9C; b8 = 8'h07; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_done", done8, 0);
        chk("mid_rst_diff", diff8, 0);
        chk("mid_rst_bout", bout8, 0);
        chk("mid_rst_ovf", ovf8, 0);
        repeat (15) @(posedge clk);
        #1;
        run8(8'h9C, 8'h07, 1'b0);
        drain(50);

        // WIDTH=4 exhaustive sweep
        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                for (int ci = 0; ci < 2; ci++)
                    run4(4'(ai), 4'(bi), 1'(ci));
        drain(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial ripple-borrow subtractor. Computes diff = a - b - bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Complements the combinational full-adder datapath. Used wherever area matters more than latency.
- Operands are captured on a start handshake. The result is presented with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand and result width in bits (WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured when start accepted
- b  input  WIDTH  subtrahend, captured when start accepted
- bin  input  1  borrow-in, captured when start accepted
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse, result valid
- diff  output  WIDTH  difference (a - b - bin) mod 2^WIDTH
- bout  output  1  final borrow-out (1 when a < b + bin, unsigned)
- ovf  output  1  signed overflow of two's-complement subtraction

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high, on clk/rst.
  - When rst is high at a rising edge: state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, bit counter=0, borrow register=0, operand shift registers=0.
  - rst overrides start and any in-flight operation; a partial result is discarded, never flagged done.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: load a into the A shift register, b into the B shift register, and bin into the borrow register. Clear the counter and go to SHIFT; busy=1.
  - Also capture the sign bits a[WIDTH-1] and b[WIDTH-1] for ovf.
  - With start=0: stay in IDLE; outputs hold their last values.
- SHIFT (one bit per edge):
  - Let x=A[0], y=B[0], br=borrow. Then d = x^y^br and br_next = (~x&y) | (~(x^y)&br).
  - d shifts into the MSB of the result register (right shift), so after WIDTH shifts bit 0 sits at LSB. A and B shift right, borrow<=br_next, and the counter increments.
  - When the counter reaches WIDTH-1 at an edge (the WIDTH-th bit processed), go to DONE.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - diff = result register; bout = final borrow; ovf = (sa ^ sb) & (sa ^ diff[WIDTH-1]).
  - Next edge returns to IDLE with done=0.
- Latency and timing:
  - If start is accepted at edge E0, busy is high from E0 to E0+WIDTH, and done is high for exactly the cycle following edge E0+WIDTH.
  - Throughput is one result per WIDTH+2 cycles when start is held high continuously.
- Outputs are stable:
  - diff, bout and ovf update only on entry to DONE and hold until the next DONE or reset.
  - Intermediate shift values are never visible on diff.
- start handling:
  - start is ignored in SHIFT and DONE; it is not queued.
  - Inputs a, b and bin may change freely after acceptance without affecting the result.
- Boundary cases:
  - a == b with bin=0: diff=0, bout=0.
  - a=0, b=0, bin=1: diff=all ones, bout=1.
  - Maximum operands (a=b=2^WIDTH-1, bin=1): diff=all ones, bout=1.
- Counter width is clog2(WIDTH); there is no wrap-around beyond WIDTH-1.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start pulse -> done exactly 9 cycles after the start edge, diff=0x02, bout=0, ovf=0; busy high for 8 cycles.
- WIDTH=8, a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0; next run a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- WIDTH=8, a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- Start a=0x10, b=0x01, then pulse start again mid-SHIFT with a=0xAA, and change a/b before done -> diff=0x0F (second start ignored). Hold start high -> back-to-back results every 10 cycles.
- Assert rst at the 4th SHIFT cycle -> next cycle busy=0, done=0, diff=0, bout=0, ovf=0; no done pulse follows. A fresh start afterwards gives the correct result.
- WIDTH=4, exhaustive: all 16x16x2 combinations of a, b, bin -> {bout,diff} == a - b - bin (5-bit two's-complement), and ovf matches the signed reference every time.
